// File: rtl/seq_onehot_decoder_pkg.sv
// ============================================================================
// Module   : seq_onehot_decoder_pkg
// Purpose  : Mode encodings and one-hot encode helper for seq_onehot_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_onehot_decoder_pkg;

    localparam logic [1:0] MODE_LATCH = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    // Encoder is sized for the widest supported select; callers truncate.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    function automatic logic [MAX_OUT_W-1:0] onehot_enc(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_onehot_decoder_scan_timer.sv
// ============================================================================
// Module   : seq_onehot_decoder_scan_timer
// Purpose  : Dwell counter, ring index and wrap pulse for the SCAN mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_onehot_decoder_scan_timer #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap
);

    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               wrap_pre_q, wrap_pre_d;
    logic               wrap_q, wrap_d;

    // The index wraps on one edge, but the decoder shows onehot(0) one edge
    // later, so the wrap flag is staged once to line up with that output.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wrap_pre_d = 1'b0;
        wrap_d     = wrap_pre_q;
        if (clr) begin
            cnt_d  = '0;
            idx_d  = '0;
            wrap_d = 1'b0;
        end else if (cnt_q == dwell) begin
            cnt_d      = '0;
            // Natural overflow at IDX_MAX covers an index left above last.
            wrap_pre_d = (idx_q == last) || (idx_q == IDX_MAX);
            idx_d      = (idx_q == last) ? '0 : idx_q + SEL_W'(1);
        end else begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            wrap_pre_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wrap_pre_q <= wrap_pre_d;
            wrap_q     <= wrap_d;
        end
    end

    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

`default_nettype wire

// File: rtl/seq_onehot_decoder.sv
// ============================================================================
// Module   : seq_onehot_decoder
// Purpose  : Registered SEL_W-to-2^SEL_W one-hot decoder with LATCH, PULSE
//            and (with SEQ_ONEHOT_DECODER_SCAN_EN defined) SCAN modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_onehot_decoder
    import seq_onehot_decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 sel_valid,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [SEL_W-1:0]     last,
    output logic [2**SEL_W-1:0]  out,
    output logic [SEL_W-1:0]     out_idx,
    output logic                 wrap
);

    localparam int OUT_W = 2 ** SEL_W;

    logic [OUT_W-1:0] out_q, out_d;
    logic [SEL_W-1:0] out_idx_q, out_idx_d;
    logic [1:0]       mode_q, mode_d;

    logic             w_clear;
    logic [OUT_W-1:0] w_sel_onehot;

    assign w_clear      = !enable || (mode != mode_q);
    assign w_sel_onehot = OUT_W'(onehot_enc(MAX_SEL_W'(sel)));

`ifdef SEQ_ONEHOT_DECODER_SCAN_EN
    logic             w_scan_run;
    logic [SEL_W-1:0] w_scan_idx;
    logic [OUT_W-1:0] w_scan_onehot;
    logic             w_scan_wrap;

    // Timer is held cleared whenever this edge is not a running SCAN edge.
    assign w_scan_run    = !w_clear && (mode_q == MODE_SCAN);
    assign w_scan_onehot = OUT_W'(onehot_enc(MAX_SEL_W'(w_scan_idx)));

    seq_onehot_decoder_scan_timer #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) u_scan_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!w_scan_run),
        .dwell (dwell),
        .last  (last),
        .idx   (w_scan_idx),
        .wrap  (w_scan_wrap)
    );

    assign wrap = w_scan_wrap;
`else
    logic w_unused_scan_cfg;
    assign w_unused_scan_cfg = ^{dwell, last};
    assign wrap              = 1'b0;
`endif

    always_comb begin
        out_d     = out_q;
        out_idx_d = out_idx_q;
        mode_d    = mode;
        if (w_clear) begin
            out_d     = '0;
            out_idx_d = '0;
        end else begin
            case (mode_q)
                MODE_LATCH: begin
                    if (sel_valid) begin
                        out_d     = w_sel_onehot;
                        out_idx_d = sel;
                    end
                end
                MODE_PULSE: begin
                    out_d     = sel_valid ? w_sel_onehot : '0;
                    out_idx_d = sel_valid ? sel : '0;
                end
`ifdef SEQ_ONEHOT_DECODER_SCAN_EN
                MODE_SCAN: begin
                    out_d     = w_scan_onehot;
                    out_idx_d = w_scan_idx;
                end
`endif
                default: begin
                    out_d     = '0;
                    out_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_idx_q <= '0;
            mode_q    <= MODE_LATCH;
        end else begin
            out_q     <= out_d;
            out_idx_q <= out_idx_d;
            mode_q    <= mode_d;
        end
    end

    assign out     = out_q;
    assign out_idx = out_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_onehot_decoder.sv
// ============================================================================
// Module   : tb_seq_onehot_decoder
// Purpose  : Self-checking bench for seq_onehot_decoder (SEL_W=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_onehot_decoder;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [2:0]  sel;
    logic        sel_valid;
    logic [15:0] dwell;
    logic [2:0]  last;
    logic [7:0]  out;
    logic [2:0]  out_idx;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [2:0] sel;
        logic       vld;
        logic [7:0] exp_out;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs [18];

    seq_onehot_decoder #(
        .SEL_W   (3),
        .DWELL_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .sel       (sel),
        .sel_valid (sel_valid),
        .dwell     (dwell),
        .last      (last),
        .out       (out),
        .out_idx   (out_idx),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] eo, input logic [2:0] ei,
                             input logic ew);
        check({name, ".out"}, 32'(out), 32'(eo));
        check({name, ".out_idx"}, 32'(out_idx), 32'(ei));
        check({name, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    task automatic drive(input logic en, input logic [1:0] m, input logic [2:0] s,
                         input logic v);
        enable    = en;
        mode      = m;
        sel       = s;
        sel_valid = v;
    endtask

    initial begin
        // {en, mode, sel, valid, expected out, expected out_idx}
        vecs[0]  = '{1'b1, 2'd0, 3'd2, 1'b1, 8'h04, 3'd2};
        vecs[1]  = '{1'b1, 2'd1, 3'd7, 1'b1, 8'h00, 3'd0};
        vecs[2]  = '{1'b1, 2'd1, 3'd7, 1'b1, 8'h80, 3'd7};
        vecs[3]  = '{1'b1, 2'd1, 3'd7, 1'b1, 8'h80, 3'd7};
        vecs[4]  = '{1'b1, 2'd1, 3'd0, 1'b1, 8'h01, 3'd0};
        vecs[5]  = '{1'b1, 2'd1, 3'd3, 1'b0, 8'h00, 3'd0};
        vecs[6]  = '{1'b1, 2'd0, 3'd6, 1'b1, 8'h00, 3'd0};
        vecs[7]  = '{1'b1, 2'd0, 3'd6, 1'b1, 8'h40, 3'd6};
        vecs[8]  = '{1'b0, 2'd0, 3'd6, 1'b1, 8'h00, 3'd0};
        vecs[9]  = '{1'b1, 2'd0, 3'd1, 1'b0, 8'h00, 3'd0};
        vecs[10] = '{1'b1, 2'd0, 3'd1, 1'b0, 8'h00, 3'd0};
        vecs[11] = '{1'b1, 2'd0, 3'd3, 1'b1, 8'h08, 3'd3};
        vecs[12] = '{1'b1, 2'd3, 3'd3, 1'b1, 8'h00, 3'd0};
        vecs[13] = '{1'b1, 2'd3, 3'd3, 1'b1, 8'h00, 3'd0};
        vecs[14] = '{1'b1, 2'd0, 3'd4, 1'b1, 8'h00, 3'd0};
        vecs[15] = '{1'b1, 2'd0, 3'd4, 1'b1, 8'h10, 3'd4};
        vecs[16] = '{1'b1, 2'd0, 3'd5, 1'b0, 8'h10, 3'd4};
        vecs[17] = '{1'b1, 2'd2, 3'd6, 1'b1, 8'h00, 3'd0};

        rst_n = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 1'b0);
        dwell = 16'd2;
        last  = 3'd3;
        #12;
        check_all("reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // LATCH: one valid then ten idle cycles with a changing sel
        drive(1'b1, 2'd0, 3'd5, 1'b1);
        step();
        check_all("latch5", 8'h20, 3'd5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd0, 3'(i), 1'b0);
            step();
            check_all($sformatf("latch_hold%0d", i), 8'h20, 3'd5, 1'b0);
        end

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].vld);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_idx, 1'b0);
        end

`ifdef SEQ_ONEHOT_DECODER_SCAN_EN
        // SCAN dwell=2 last=3, first run edge follows the clear above
        drive(1'b1, 2'd2, 3'd6, 1'b1);
        for (int k = 0; k < 15; k++) begin
            logic [7:0] eo;
            logic [2:0] ei;
            ei = (k < 12) ? 3'(k / 3) : 3'd0;
            eo = 8'h01 << ei;
            step();
            check_all($sformatf("scan%0d", k), eo, ei, (k == 12) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 20 && out !== 8'h08; i++) step();
        check("scan_reach_08", 32'(out), 32'h08);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("scan_async_reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // dwell=0 last=0: constant onehot(0), wrap every cycle once running
        dwell = 16'd0;
        last  = 3'd0;
        drive(1'b1, 2'd2, 3'd0, 1'b0);
        step();
        check_all("scan00_clear", 8'h00, 3'd0, 1'b0);
        step();
        check_all("scan00_first", 8'h01, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("scan00_%0d", i), 8'h01, 3'd0, 1'b1);
        end
`else
        drive(1'b1, 2'd2, 3'd6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_all($sformatf("noscan%0d", i), 8'h00, 3'd0, 1'b0);
        end
`endif

        // Asynchronous reset while LATCH holds a value
        drive(1'b1, 2'd0, 3'd7, 1'b1);
        step();
        step();
        check_all("latch7", 8'h80, 3'd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("latch_async_reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 3'd1, 1'b0);
        step();
        check_all("after_reset_idle", 8'h00, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_onehot_decoder.md
# seq_onehot_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder for the CPU datapath and its front-panel I/O. It replaces the fixed combinational 3-to-8 decode with three modes: latched select, single-cycle strobe, and auto-scanning ring select with programmable dwell. Consumers are register-file and peripheral write-enables (LATCH/PULSE) and multiplexed 7-segment/LED digit drive (SCAN).

## Interface
- SEL_W, 3, select width; OUT_W = 2**SEL_W is a derived localparam, not overridable
- DWELL_W, 16, dwell counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; low forces outputs to 0
- mode  in  2  00 LATCH, 01 PULSE, 10 SCAN, 11 reserved
- sel  in  SEL_W  select index (LATCH/PULSE)
- sel_valid  in  1  sel qualifier, sampled each rising edge
- dwell  in  DWELL_W  SCAN: cycles per position minus 1
- last  in  SEL_W  SCAN: highest index visited, wrap to 0 after it
- out  out  OUT_W  one-hot or all-zero output
- out_idx  out  SEL_W  index of the asserted out bit; 0 when out is 0
- wrap  out  1  one-cycle pulse when SCAN wraps last -> 0

## Operation
- Reset (async, rst_n low): out=0, out_idx=0, wrap=0, scan index=0, dwell count=0, registered mode=00.
- All outputs registered; out never has more than one bit set.
- enable low (sampled): next edge out=0, out_idx=0, wrap=0, index=0, count=0. sel_valid ignored.
- Mode change (mode != registered mode, enable high): same clear as enable low for that edge; new mode's behaviour starts next edge.
- LATCH: sel_valid high -> out<=onehot(sel); otherwise out holds. After clear, out stays 0 until first sel_valid.
- PULSE: out<=onehot(sel) when sel_valid high, else out<=0. Back-to-back valids give back-to-back one-cycle strobes (may differ per cycle).
- SCAN: each edge out<=onehot(index); if count==dwell then count<=0 and index<=(index==last)?0:index+1, else count<=count+1. wrap<=1 on the edge where index goes last->0, else 0. sel/sel_valid ignored.
- dwell=0: advance every cycle. last=0: out stays onehot(0), wrap pulses every dwell+1 cycles.
- dwell/last changes take effect on the next comparison; if index>last after a change, index continues to wrap at 2^SEL_W-1 -> 0 once, then honours last (wrap asserted on that 0 transition).
- Mode 11: out=0, out_idx=0, wrap=0 held.

## Timing
- LATCH/PULSE latency: 1 cycle from sampled sel_valid to out.
- SCAN: clear edge t, out=0 during cycle t..t+1; out=onehot(0) from edge t+1 for exactly dwell+1 cycles; then onehot(1), etc.
- wrap coincides with the first cycle out=onehot(0) after onehot(last).
- Reset deassertion: first functional edge is the first rising edge with rst_n high; no synchroniser inside block (deassertion sync is top-level's job).

## Configuration
- SEQ_ONEHOT_DECODER_SCAN_EN defined: SCAN mode and dwell counter built as above.
- Not defined: mode 10 behaves as mode 11 (out=0); dwell/last ports present but ignored; wrap tied 0; counter logic absent.

## Structure
- Shared package: mode encoding constants (MODE_LATCH=2'b00, MODE_PULSE=2'b01, MODE_SCAN=2'b10, MODE_RSVD=2'b11) and onehot encode function.
- One sub-module: scan_timer (dwell count, index, wrap generation), instantiated only under SEQ_ONEHOT_DECODER_SCAN_EN.

## Test plan
- Reset mid-SCAN (out=8'h08): assert rst_n low -> out=8'h00, out_idx=0, wrap=0 immediately, without clock edge.
- LATCH, SEL_W=3: sel=5 valid one cycle -> out=8'h20 next edge, held 10 cycles; sel=2 valid -> out=8'h04.
- PULSE: valid sel=7,7,0 consecutive -> out=8'h80,8'h80,8'h01, then 8'h00.
- SCAN dwell=2 last=3: out 8'h01,8'h02,8'h04,8'h08 each 3 cycles, then 8'h01 with wrap=1 for one cycle; dwell=0 last=0 -> out=8'h01 constant, wrap every cycle.
- enable low for 1 cycle during LATCH out=8'h40 -> out=8'h00 and stays 0 after enable returns until next sel_valid.
- Mode change LATCH->SCAN with sel_valid high same cycle -> out=8'h00 one cycle, then 8'h01; build without SEQ_ONEHOT_DECODER_SCAN_EN -> mode 10 gives out=0, wrap=0.
